// File: rtl/module_tick_pkg.sv
// Shared types and defaults for the tick scheduler.
// Imported by the scheduler top.
package module_tick_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        UPD
    } state_t;

    localparam int CLK_HZ = 27_000_000;
    localparam int DEF_DIV = CLK_HZ / 1000;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/module_tick_chan.sv
// One divider channel: counter, divisor register, tick strobe, square output.
// Priority is clear/load over counting.
module module_tick_chan #(
    parameter int CNT_W = 25,
    parameter int DEF_DIV = 27_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            div  <= CNT_W'(DEF_DIV);
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (clr || load) begin
            if (load) div <= div_in;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en && (div != '0)) begin
            // div is nonzero here, so div - 1 cannot underflow
            if (cnt == div - CNT_W'(1)) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/module_tick_sched.sv
// Clock-enable scheduler: run/stop/update FSM driving N_CH divider channels.
// Config writes go through a one-cycle UPD state.
module module_tick_sched #(
    parameter int CLK_HZ = module_tick_pkg::CLK_HZ,
    parameter int N_CH = 3,
    parameter int CNT_W = 25,
    parameter int DEF_DIV = CLK_HZ / 1000,
    localparam int CH_W = module_tick_pkg::ch_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq,
    output logic             busy
);

    import module_tick_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             hs;
    logic [CH_W-1:0]  cap_ch;
    logic [CNT_W-1:0] cap_div;
    logic             en;
    logic             clr;

    assign hs = cfg_valid && cfg_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (hs) state_nxt = UPD;
                else if (run) state_nxt = RUN;
            end
            RUN: begin
                if (hs) state_nxt = UPD;
                else if (!run) state_nxt = IDLE;
            end
            UPD: state_nxt = run ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            cap_ch    <= '0;
            cap_div   <= '0;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt != UPD);
            busy      <= (state_nxt != IDLE);
            cfg_err   <= hs && (int'(cfg_ch) >= N_CH);
            if (hs) begin
                cap_ch  <= cfg_ch;
                cap_div <= cfg_div;
            end
        end
    end

    // Counters restart from zero whenever the FSM falls back to IDLE
    assign en  = (state != IDLE);
    assign clr = en && (state_nxt == IDLE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic load;
        assign load = (state == UPD) && (int'(cap_ch) == i);

        module_tick_chan #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .clr   (clr),
            .load  (load),
            .div_in(cap_div),
            .tick  (tick[i]),
            .sq    (sq[i])
        );
    end

endmodule

// File: tb/tb_module_tick_sched.sv
// Directed plus random bench for module_tick_sched (N_CH=3, CNT_W=8, DEF_DIV=5).
// Reference model predicts ticks from elapsed cycles modulo the divisor.
module tb_module_tick_sched;

    localparam int N_CH = 3;
    localparam int CNT_W = 8;
    localparam int DEF_DIV = 5;

    typedef enum int {M_IDLE, M_RUN, M_UPD} mode_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  sq;
    logic             busy;

    int tests = 0;
    int fails = 0;

    mode_t          m_mode;
    longint         cyc;
    int             m_div[N_CH];
    longint         m_org[N_CH];
    logic [N_CH-1:0] m_tick;
    logic [N_CH-1:0] m_sq;
    logic           m_ready;
    logic           m_busy;
    logic           m_err;
    int             m_cap_ch;
    int             m_cap_div;

    module_tick_sched #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .sq       (sq),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h",
                   tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("tick", 8'(tick), 8'(m_tick));
        chk("sq", 8'(sq), 8'(m_sq));
        chk("cfg_ready", 8'(cfg_ready), 8'(m_ready));
        chk("busy", 8'(busy), 8'(m_busy));
        chk("cfg_err", 8'(cfg_err), 8'(m_err));
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_tick  = '0;
        m_sq    = '0;
        m_ready = 1'b0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            m_div[i] = DEF_DIV;
            m_org[i] = cyc;
        end
    endtask

    task automatic model_edge();
        logic  hs;
        logic  active;
        mode_t nxt;
        hs  = cfg_valid && m_ready;
        nxt = m_mode;
        case (m_mode)
            M_IDLE: nxt = hs ? M_UPD : (run ? M_RUN : M_IDLE);
            M_RUN:  nxt = hs ? M_UPD : (run ? M_RUN : M_IDLE);
            default: nxt = run ? M_RUN : M_IDLE;
        endcase
        active = (m_mode != M_IDLE);
        for (int i = 0; i < N_CH; i++) begin
            if (m_mode == M_UPD && m_cap_ch == i) begin
                m_div[i]  = m_cap_div;
                m_org[i]  = cyc;
                m_tick[i] = 1'b0;
            end else if (active && nxt == M_IDLE) begin
                m_tick[i] = 1'b0;
            end else if (active) begin
                m_tick[i] = (m_div[i] != 0) &&
                            ((cyc - m_org[i]) % m_div[i] == 0);
                if (m_tick[i]) m_sq[i] = ~m_sq[i];
            end else begin
                m_tick[i] = 1'b0;
            end
            if (m_mode == M_IDLE && nxt != M_IDLE) m_org[i] = cyc;
        end
        m_err = hs && (int'(cfg_ch) >= N_CH);
        if (hs) begin
            m_cap_ch  = int'(cfg_ch);
            m_cap_div = int'(cfg_div);
        end
        m_ready = (nxt != M_UPD);
        m_busy  = (nxt != M_IDLE);
        m_mode  = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg(input int ch, input int dv);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CNT_W'(dv);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        cyc       = 0;
        rst_n     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        m_cap_ch  = 0;
        m_cap_div = 0;
        #1;
        model_reset();
        check_all();
        steps(2);
        rst_n = 1'b1;
        run   = 1'b1;
        steps(25);

        // asynchronous reset in the middle of running
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        steps(2);
        rst_n = 1'b1;
        steps(30);

        // reprogram ch0 while idle, then start
        run = 1'b0;
        steps(3);
        cfg(0, 4);
        steps(2);
        run = 1'b1;
        steps(20);

        // ch1 to divide-by-one while running
        cfg(1, 1);
        steps(12);

        // disable ch2, then restart it with period 3
        cfg(2, 0);
        steps(15);
        cfg(2, 3);
        steps(12);

        // out-of-range channel
        cfg(3, 7);
        steps(10);

        // run drops in the handshake cycle
        run = 1'b0;
        cfg(0, 6);
        steps(10);
        run = 1'b1;
        steps(16);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = CNT_W'($urandom_range(0, 9));
            step();
        end
        cfg_valid = 1'b0;
        steps(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
